// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stalls on RAW hazards, flushes on taken branches,
// freezes on data-memory wait states, and counts non-RUN cycles.
//
// state        | meaning
// RUN          | all stages advance, ID instruction issues into EX
// RAW_STALL    | PC and IF_ID hold, bubble inserted into ID_EX, rest advance
// MEM_WAIT     | whole pipeline frozen until data memory completes
// FLUSH        | taken branch: IF_ID flushed, bubble into ID_EX, rest advance
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 6,
   parameter bit WB_SPLIT   = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  id_wr_en,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_en,
   output logic                  idex_bubble,
   output logic                  exmem_en,
   output logic                  memwb_en,
   output logic [1:0]            ctrl_state,
   output logic [CNT_W-1:0]      stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_RAW_STALL = 2'd1,
      ST_MEM_WAIT  = 2'd2,
      ST_FLUSH     = 2'd3
   } ctrl_state_e;

   ctrl_state_e ctrl_state_q, ctrl_state_d, dec;

   logic                  sb_ex_vld_q, sb_ex_vld_d;
   logic                  sb_mem_vld_q, sb_mem_vld_d;
   logic                  sb_wb_vld_q, sb_wb_vld_d;
   logic [REG_ADDR_W-1:0] sb_ex_rd_q, sb_ex_rd_d;
   logic [REG_ADDR_W-1:0] sb_mem_rd_q, sb_mem_rd_d;
   logic [REG_ADDR_W-1:0] sb_wb_rd_q, sb_wb_rd_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic                  rs1_hit, rs2_hit, raw;

   // Register 0 is deliberately not special-cased.
   always_comb begin
      rs1_hit = (sb_ex_vld_q  && (sb_ex_rd_q  == id_rs1)) ||
                (sb_mem_vld_q && (sb_mem_rd_q == id_rs1)) ||
                (!WB_SPLIT && sb_wb_vld_q && (sb_wb_rd_q == id_rs1));
      rs2_hit = (sb_ex_vld_q  && (sb_ex_rd_q  == id_rs2)) ||
                (sb_mem_vld_q && (sb_mem_rd_q == id_rs2)) ||
                (!WB_SPLIT && sb_wb_vld_q && (sb_wb_rd_q == id_rs2));
      raw     = id_valid && ((id_use_rs1 && rs1_hit) || (id_use_rs2 && rs2_hit));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_state_q <= ST_RUN;
         sb_ex_vld_q  <= 1'b0;
         sb_mem_vld_q <= 1'b0;
         sb_wb_vld_q  <= 1'b0;
         sb_ex_rd_q   <= '0;
         sb_mem_rd_q  <= '0;
         sb_wb_rd_q   <= '0;
         stall_cnt_q  <= '0;
      end else begin
         ctrl_state_q <= ctrl_state_d;
         sb_ex_vld_q  <= sb_ex_vld_d;
         sb_mem_vld_q <= sb_mem_vld_d;
         sb_wb_vld_q  <= sb_wb_vld_d;
         sb_ex_rd_q   <= sb_ex_rd_d;
         sb_mem_rd_q  <= sb_mem_rd_d;
         sb_wb_rd_q   <= sb_wb_rd_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   always_comb begin
      dec = ST_RUN;
      if (mem_req && !mem_ready) begin
         dec = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
         dec = ST_FLUSH;
      end else if (raw) begin
         dec = ST_RAW_STALL;
      end

      ctrl_state_d = dec;
      sb_ex_vld_d  = sb_ex_vld_q;
      sb_mem_vld_d = sb_mem_vld_q;
      sb_wb_vld_d  = sb_wb_vld_q;
      sb_ex_rd_d   = sb_ex_rd_q;
      sb_mem_rd_d  = sb_mem_rd_q;
      sb_wb_rd_d   = sb_wb_rd_q;
      stall_cnt_d  = stall_cnt_q;

      // A frozen pipeline keeps its scoreboard; every other decision advances it.
      if (dec != ST_MEM_WAIT) begin
         sb_wb_vld_d  = sb_mem_vld_q;
         sb_wb_rd_d   = sb_mem_rd_q;
         sb_mem_vld_d = sb_ex_vld_q;
         sb_mem_rd_d  = sb_ex_rd_q;
         sb_ex_vld_d  = (dec == ST_RUN) && id_valid && id_wr_en;
         sb_ex_rd_d   = id_rd;
      end

      if ((dec != ST_RUN) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      if (rst) begin
         ifid_en     = 1'b1;
         ifid_flush  = 1'b1;
         idex_en     = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         unique case (dec)
            ST_RUN: begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
            end
            ST_RAW_STALL: begin
               idex_en     = 1'b1;
               idex_bubble = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
            end
            ST_FLUSH: begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_en     = 1'b1;
               idex_bubble = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ctrl_state = ctrl_state_q;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (WB_SPLIT=1 and WB_SPLIT=0) share stimulus;
// a history-log model predicts decisions, enables, ctrl_state and stall_cnt.
module tb_pipeline_hazard_ctrl;

   localparam int RA_W  = 6;
   localparam int CNT_W = 12;
   localparam int MAXC  = (1 << CNT_W) - 1;

   localparam logic [6:0] RST_V   = 7'b0111100;
   localparam logic [6:0] RUN_V   = 7'b1101011;
   localparam logic [6:0] RAW_V   = 7'b0001111;
   localparam logic [6:0] MEM_V   = 7'b0000000;
   localparam logic [6:0] FLUSH_V = 7'b1111111;

   logic clk, rst;
   logic id_valid, id_use_rs1, id_use_rs2, id_wr_en;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic ex_branch_taken, mem_req, mem_ready;

   logic pc_en_s1, ifid_en_s1, ifid_flush_s1, idex_en_s1, idex_bubble_s1, exmem_en_s1, memwb_en_s1;
   logic pc_en_s0, ifid_en_s0, ifid_flush_s0, idex_en_s0, idex_bubble_s0, exmem_en_s0, memwb_en_s0;
   logic [1:0]       ctrl_state_s1, ctrl_state_s0;
   logic [CNT_W-1:0] stall_cnt_s1, stall_cnt_s0;
   logic [6:0]       outs1, outs0;

   assign outs1 = {pc_en_s1, ifid_en_s1, ifid_flush_s1, idex_en_s1, idex_bubble_s1, exmem_en_s1, memwb_en_s1};
   assign outs0 = {pc_en_s0, ifid_en_s0, ifid_flush_s0, idex_en_s0, idex_bubble_s0, exmem_en_s0, memwb_en_s0};

   pipeline_hazard_ctrl #(.REG_ADDR_W(RA_W), .WB_SPLIT(1'b1), .CNT_W(CNT_W)) u_dut_s1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_en(id_wr_en), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_s1), .ifid_en(ifid_en_s1), .ifid_flush(ifid_flush_s1), .idex_en(idex_en_s1),
      .idex_bubble(idex_bubble_s1), .exmem_en(exmem_en_s1), .memwb_en(memwb_en_s1),
      .ctrl_state(ctrl_state_s1), .stall_cnt(stall_cnt_s1));

   pipeline_hazard_ctrl #(.REG_ADDR_W(RA_W), .WB_SPLIT(1'b0), .CNT_W(CNT_W)) u_dut_s0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_en(id_wr_en), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_s0), .ifid_en(ifid_en_s0), .ifid_flush(ifid_flush_s0), .idex_en(idex_en_s0),
      .idex_bubble(idex_bubble_s0), .exmem_en(exmem_en_s0), .memwb_en(memwb_en_s0),
      .ctrl_state(ctrl_state_s0), .stall_cnt(stall_cnt_s0));

   int errors = 0;
   int checks = 0;

   // Model: log of instructions that advanced past ID (-1 = bubble / non-writer), newest last.
   int h1[$];
   int h0[$];
   int cnt1 = 0, cnt0 = 0, st1 = 0, st0 = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic bit in_window(input int h[$], input int n, input int r);
      for (int i = 0; i < n && i < h.size(); i++)
         if (h[h.size()-1-i] == r) return 1'b1;
      return 1'b0;
   endfunction

   // 0 RUN, 1 RAW_STALL, 2 MEM_WAIT, 3 FLUSH; n = number of producers still hazardous
   function automatic int exp_dec(input int h[$], input int n);
      bit hz;
      hz = id_valid && ((id_use_rs1 && in_window(h, n, int'(id_rs1))) ||
                        (id_use_rs2 && in_window(h, n, int'(id_rs2))));
      if (mem_req && !mem_ready) return 2;
      if (ex_branch_taken) return 3;
      if (hz) return 1;
      return 0;
   endfunction

   function automatic logic [6:0] outv(input int d);
      case (d)
         0: return RUN_V;
         1: return RAW_V;
         2: return MEM_V;
         default: return FLUSH_V;
      endcase
   endfunction

   function automatic int entry(input int d);
      return (d == 0 && id_valid && id_wr_en) ? int'(id_rd) : -1;
   endfunction

   task automatic tick();
      int d1, d0;
      @(posedge clk);
      if (rst) begin
         h1.delete(); h0.delete();
         cnt1 = 0; cnt0 = 0; st1 = 0; st0 = 0;
      end else begin
         d1 = exp_dec(h1, 2);
         d0 = exp_dec(h0, 3);
         if (d1 != 2) begin
            h1.push_back(entry(d1));
            if (h1.size() > 3) void'(h1.pop_front());
         end
         if (d0 != 2) begin
            h0.push_back(entry(d0));
            if (h0.size() > 3) void'(h0.pop_front());
         end
         st1 = d1; st0 = d0;
         if (d1 != 0 && cnt1 < MAXC) cnt1++;
         if (d0 != 0 && cnt0 < MAXC) cnt0++;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_wr_en = 0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      #1;
      checks++; if (pc_en_s1 !== 1'b0) begin errors++; $display("FAIL rst_pc_en: got %b want 0", pc_en_s1); end
      checks++; if (ifid_flush_s1 !== 1'b1) begin errors++; $display("FAIL rst_ifid_flush: got %b want 1", ifid_flush_s1); end
      checks++; if (outs1 !== RST_V) begin errors++; $display("FAIL rst_outs: got %b want %b", outs1, RST_V); end
      tick(); tick();
      rst = 0;
      #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL post_rst_outs: got %b want %b", outs1, RUN_V); end
      checks++; if (ctrl_state_s1 !== 2'd0) begin errors++; $display("FAIL post_rst_state: got %0d want 0", ctrl_state_s1); end
      checks++; if (stall_cnt_s1 !== '0) begin errors++; $display("FAIL post_rst_cnt: got %0d want 0", stall_cnt_s1); end
      tick();
   endtask

   task automatic test_raw_back_to_back();
      int b1, b0;
      idle(); id_valid = 1; id_wr_en = 1; id_rd = 5;
      #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL raw_prod_run: got %b want %b", outs1, RUN_V); end
      tick();
      b1 = cnt1; b0 = cnt0;
      id_wr_en = 0; id_rd = 0; id_rs1 = 5; id_use_rs1 = 1;
      #1;
      checks++; if (outs1 !== RAW_V) begin errors++; $display("FAIL raw_c1: got %b want %b", outs1, RAW_V); end
      checks++; if (outs0 !== RAW_V) begin errors++; $display("FAIL raw_c1_wb0: got %b want %b", outs0, RAW_V); end
      tick(); #1;
      checks++; if (outs1 !== RAW_V) begin errors++; $display("FAIL raw_c2: got %b want %b", outs1, RAW_V); end
      checks++; if (ctrl_state_s1 !== 2'd1) begin errors++; $display("FAIL raw_c2_state: got %0d want 1", ctrl_state_s1); end
      tick(); #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL raw_c3_run: got %b want %b", outs1, RUN_V); end
      checks++; if (ctrl_state_s1 !== 2'd1) begin errors++; $display("FAIL raw_c3_state: got %0d want 1", ctrl_state_s1); end
      checks++; if (stall_cnt_s1 !== CNT_W'(b1 + 2)) begin errors++; $display("FAIL raw_cnt: got %0d want %0d", stall_cnt_s1, b1 + 2); end
      checks++; if (outs0 !== RAW_V) begin errors++; $display("FAIL raw_c3_wb0: got %b want %b", outs0, RAW_V); end
      tick(); #1;
      checks++; if (outs0 !== RUN_V) begin errors++; $display("FAIL raw_c4_wb0_run: got %b want %b", outs0, RUN_V); end
      checks++; if (stall_cnt_s0 !== CNT_W'(b0 + 3)) begin errors++; $display("FAIL raw_cnt_wb0: got %0d want %0d", stall_cnt_s0, b0 + 3); end
      tick(); idle(); tick();
   endtask

   task automatic test_branch();
      int b1;
      idle(); id_valid = 1; id_wr_en = 1; id_rd = 7;
      tick();
      b1 = cnt1;
      id_wr_en = 0; id_rd = 0; id_rs2 = 7; id_use_rs2 = 1; ex_branch_taken = 1;
      #1;
      checks++; if (outs1 !== FLUSH_V) begin errors++; $display("FAIL br_flush: got %b want %b", outs1, FLUSH_V); end
      tick();
      idle(); id_valid = 1; id_rs1 = 6; id_use_rs1 = 1;
      #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL br_next_run: got %b want %b", outs1, RUN_V); end
      checks++; if (ctrl_state_s1 !== 2'd3) begin errors++; $display("FAIL br_state: got %0d want 3", ctrl_state_s1); end
      checks++; if (stall_cnt_s1 !== CNT_W'(b1 + 1)) begin errors++; $display("FAIL br_cnt: got %0d want %0d", stall_cnt_s1, b1 + 1); end
      tick(); idle(); tick(); tick();
   endtask

   task automatic test_mem_wait();
      int b1;
      idle(); id_valid = 1; id_wr_en = 1; id_rd = 9;
      tick();
      idle(); b1 = cnt1; mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (outs1 !== MEM_V) begin errors++; $display("FAIL mem_wait_%0d: got %b want %b", i, outs1, MEM_V); end
         tick();
      end
      mem_ready = 1;
      #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL mem_done_run: got %b want %b", outs1, RUN_V); end
      checks++; if (ctrl_state_s1 !== 2'd2) begin errors++; $display("FAIL mem_state: got %0d want 2", ctrl_state_s1); end
      checks++; if (stall_cnt_s1 !== CNT_W'(b1 + 3)) begin errors++; $display("FAIL mem_cnt: got %0d want %0d", stall_cnt_s1, b1 + 3); end
      tick();
      idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
      #1;
      checks++; if (outs1 !== RAW_V) begin errors++; $display("FAIL mem_sb_held: got %b want %b", outs1, RAW_V); end
      tick(); idle(); mem_ready = 1;
      #1;
      checks++; if (outs1 !== RUN_V) begin errors++; $display("FAIL ready_no_req: got %b want %b", outs1, RUN_V); end
      tick(); idle(); tick();
   endtask

   task automatic test_simultaneous();
      int b1;
      idle(); b1 = cnt1; mem_req = 1; ex_branch_taken = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (outs1 !== MEM_V) begin errors++; $display("FAIL sim_wait_%0d: got %b want %b", i, outs1, MEM_V); end
         tick();
      end
      mem_ready = 1;
      #1;
      checks++; if (outs1 !== FLUSH_V) begin errors++; $display("FAIL sim_flush: got %b want %b", outs1, FLUSH_V); end
      checks++; if (ctrl_state_s1 !== 2'd2) begin errors++; $display("FAIL sim_state_mem: got %0d want 2", ctrl_state_s1); end
      tick(); idle();
      #1;
      checks++; if (ctrl_state_s1 !== 2'd3) begin errors++; $display("FAIL sim_state_flush: got %0d want 3", ctrl_state_s1); end
      checks++; if (stall_cnt_s1 !== CNT_W'(b1 + 3)) begin errors++; $display("FAIL sim_cnt: got %0d want %0d", stall_cnt_s1, b1 + 3); end
      tick();
   endtask

   task automatic test_saturation();
      rst = 1; idle(); tick();
      rst = 0; mem_req = 1;
      repeat (MAXC) tick();
      #1;
      checks++; if (stall_cnt_s1 !== CNT_W'(MAXC)) begin errors++; $display("FAIL sat_reach: got %0d want %0d", stall_cnt_s1, MAXC); end
      repeat (6) tick();
      #1;
      checks++; if (stall_cnt_s1 !== CNT_W'(MAXC)) begin errors++; $display("FAIL sat_hold: got %0d want %0d", stall_cnt_s1, MAXC); end
      checks++; if (stall_cnt_s0 !== CNT_W'(MAXC)) begin errors++; $display("FAIL sat_hold_wb0: got %0d want %0d", stall_cnt_s0, MAXC); end
      rst = 1; tick();
      #1;
      checks++; if (stall_cnt_s1 !== '0) begin errors++; $display("FAIL sat_reset: got %0d want 0", stall_cnt_s1); end
      rst = 0; idle(); tick();
   endtask

   task automatic test_random();
      logic [6:0] e1, e0;
      rst = 1; idle(); tick();
      rst = 0;
      for (int n = 0; n < 600; n++) begin
         rst             = ($urandom_range(0, 59) == 0);
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rs1          = RA_W'($urandom_range(0, 3));
         id_rs2          = RA_W'($urandom_range(0, 3));
         id_rd           = RA_W'($urandom_range(0, 3));
         id_use_rs1      = 1'($urandom_range(0, 1));
         id_use_rs2      = 1'($urandom_range(0, 1));
         id_wr_en        = ($urandom_range(0, 3) != 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         mem_req         = ($urandom_range(0, 3) == 0);
         mem_ready       = 1'($urandom_range(0, 1));
         #1;
         e1 = rst ? RST_V : outv(exp_dec(h1, 2));
         e0 = rst ? RST_V : outv(exp_dec(h0, 3));
         checks++; if (outs1 !== e1) begin errors++; $display("FAIL rnd_outs_s1 @%0d: got %b want %b", n, outs1, e1); end
         checks++; if (outs0 !== e0) begin errors++; $display("FAIL rnd_outs_s0 @%0d: got %b want %b", n, outs0, e0); end
         checks++; if (ctrl_state_s1 !== 2'(st1)) begin errors++; $display("FAIL rnd_state_s1 @%0d: got %0d want %0d", n, ctrl_state_s1, st1); end
         checks++; if (ctrl_state_s0 !== 2'(st0)) begin errors++; $display("FAIL rnd_state_s0 @%0d: got %0d want %0d", n, ctrl_state_s0, st0); end
         checks++; if (stall_cnt_s1 !== CNT_W'(cnt1)) begin errors++; $display("FAIL rnd_cnt_s1 @%0d: got %0d want %0d", n, stall_cnt_s1, cnt1); end
         checks++; if (stall_cnt_s0 !== CNT_W'(cnt0)) begin errors++; $display("FAIL rnd_cnt_s0 @%0d: got %0d want %0d", n, stall_cnt_s0, cnt0); end
         tick();
      end
      rst = 0; idle(); tick();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_raw_back_to_back();
      test_branch();
      test_mem_wait();
      test_simultaneous();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
